// File: rtl/fetch_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode_stage
// Description : Front end of the accumulator CPU. Owns the program counter,
//               fetches one OP_W+ADDR_W-bit instruction per cycle from a
//               combinational instruction memory, decodes it into the control
//               bundle for the ID/MEM pipeline register and resolves
//               HLT/SKZ/JMP locally, so no flush is ever required.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               start             - leave IDLE/HALTED and begin fetching
//               stall             - downstream hold (ignored in IDLE/HALTED)
//               acc_zero          - accumulator is zero, used by SKZ
//               imem_addr/imem_data - instruction memory read port
//               pc                - current program counter
//               opcode, addr, mem_rd, mem_we, acc_we, acc_control, valid
//                                 - registered decode bundle for ID/MEM
//               halted            - FSM is in HALTED
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_stage #(
    parameter int                ADDR_W   = 5,
    parameter int                OP_W     = 3,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   acc_zero,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [OP_W+ADDR_W-1:0] imem_data,
    output logic [ADDR_W-1:0]      pc,
    output logic [OP_W-1:0]        opcode,
    output logic [ADDR_W-1:0]      addr,
    output logic                   mem_rd,
    output logic                   mem_we,
    output logic                   acc_we,
    output logic                   acc_control,
    output logic                   valid,
    output logic                   halted
);

    localparam logic [OP_W-1:0] c_op_hlt = OP_W'(0);
    localparam logic [OP_W-1:0] c_op_skz = OP_W'(1);
    localparam logic [OP_W-1:0] c_op_add = OP_W'(2);
    localparam logic [OP_W-1:0] c_op_and = OP_W'(3);
    localparam logic [OP_W-1:0] c_op_xor = OP_W'(4);
    localparam logic [OP_W-1:0] c_op_lda = OP_W'(5);
    localparam logic [OP_W-1:0] c_op_sto = OP_W'(6);
    localparam logic [OP_W-1:0] c_op_jmp = OP_W'(7);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [OP_W-1:0]    opcode_q, opcode_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_we_q, mem_we_d;
    logic               acc_we_q, acc_we_d;
    logic               acc_ctl_q, acc_ctl_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;

    logic [OP_W-1:0]    w_op;
    logic [ADDR_W-1:0]  w_operand;

    assign w_op      = imem_data[OP_W+ADDR_W-1:ADDR_W];
    assign w_operand = imem_data[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            opcode_q  <= '0;
            addr_q    <= '0;
            mem_rd_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            acc_we_q  <= 1'b0;
            acc_ctl_q <= 1'b0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            mem_rd_q  <= mem_rd_d;
            mem_we_q  <= mem_we_d;
            acc_we_q  <= acc_we_d;
            acc_ctl_q <= acc_ctl_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
        end
    end

    // Defaults hold every register, which is exactly the stalled-RUN
    // behaviour; IDLE/HALTED overwrite the bundle with a bubble.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        mem_rd_d  = mem_rd_q;
        mem_we_d  = mem_we_q;
        acc_we_d  = acc_we_q;
        acc_ctl_d = acc_ctl_q;
        valid_d   = valid_q;

        case (state_q)
            S_RUN: begin
                if (!stall) begin
                    valid_d   = 1'b1;
                    opcode_d  = w_op;
                    addr_d    = w_operand;
                    mem_rd_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    acc_we_d  = 1'b0;
                    acc_ctl_d = 1'b0;
                    pc_d      = pc_q + ADDR_W'(1);
                    case (w_op)
                        c_op_hlt: state_d = S_HALTED;
                        // Skip is resolved here, in the fetch cycle.
                        c_op_skz: if (acc_zero) pc_d = pc_q + ADDR_W'(2);
                        c_op_add, c_op_and, c_op_xor: begin
                            mem_rd_d = 1'b1;
                            acc_we_d = 1'b1;
                        end
                        c_op_lda: begin
                            mem_rd_d  = 1'b1;
                            acc_we_d  = 1'b1;
                            acc_ctl_d = 1'b1;
                        end
                        c_op_sto: mem_we_d = 1'b1;
                        c_op_jmp: pc_d = w_operand;
                        default: ;
                    endcase
                end
            end
            default: begin
                // IDLE, HALTED (and any illegal encoding): emit bubbles.
                valid_d   = 1'b0;
                opcode_d  = '0;
                addr_d    = '0;
                mem_rd_d  = 1'b0;
                mem_we_d  = 1'b0;
                acc_we_d  = 1'b0;
                acc_ctl_d = 1'b0;
                if (state_q != S_IDLE && state_q != S_HALTED) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
        endcase

        halted_d = (state_d == S_HALTED);
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign opcode      = opcode_q;
    assign addr        = addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_we      = mem_we_q;
    assign acc_we      = acc_we_q;
    assign acc_control = acc_ctl_q;
    assign valid       = valid_q;
    assign halted      = halted_q;

endmodule
`default_nettype wire
